// File: rtl/mouse_receiver.sv
// PS/2 mouse receive-only deserialiser: turns 11-bit PS/2 frames into a data byte plus parity/stop status.
// Latency: BYTE_READY rises 4 CLK cycles after the stop-bit falling edge on CLK_MOUSE_IN (2 sync, 1 edge detect, 1 output register).
// Backpressure: none; each completed frame produces one BYTE_READY pulse, and READ_ENABLE low drops or ignores frames.
//
// Ports:
//   CLK             system clock, all logic on the rising edge
//   RESET           asynchronous, active-low reset
//   CLK_MOUSE_IN    raw PS/2 clock from the mouse (asynchronous, input only)
//   DATA_MOUSE_IN   raw PS/2 data from the mouse (asynchronous, input only)
//   READ_ENABLE     high = accept frames
//   BYTE_READ       last received data byte, held between pulses
//   BYTE_ERROR_CODE bit0 = parity error, bit1 = stop-bit error, held between pulses
//   BYTE_READY      one-cycle pulse marking BYTE_READ/BYTE_ERROR_CODE valid
module mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronisers and edge detect
    logic clk_meta_q, clk_sync_q, clk_dly_q;
    logic dat_meta_q, dat_sync_q;
    logic fall_q;   // registered falling-edge strobe
    logic bit_q;    // synchronised data captured alongside fall_q

    // Frame state
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Output registers
    logic [7:0] byte_q, byte_d;
    logic [1:0] err_q, err_d;
    logic       rdy_q, rdy_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_dly_q  <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_meta_q <= CLK_MOUSE_IN;
            clk_sync_q <= clk_meta_q;
            clk_dly_q  <= clk_sync_q;
            dat_meta_q <= DATA_MOUSE_IN;
            dat_sync_q <= dat_meta_q;
            // The edge strobe is registered, so the data sample is registered
            // in the same cycle to keep the two aligned.
            fall_q     <= ~clk_sync_q & clk_dly_q;
            bit_q      <= dat_sync_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'h00;
            perr_q  <= 1'b0;
            tmo_q   <= '0;
            byte_q  <= 8'h00;
            err_q   <= 2'b00;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            tmo_q   <= tmo_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        tmo_d   = tmo_q;
        byte_d  = byte_q;
        err_d   = err_q;
        rdy_d   = 1'b0;

        if (state_q == S_IDLE) begin
            tmo_d = '0;
            // A high line at the first edge is a spurious start and is ignored.
            if (fall_q && READ_ENABLE && !bit_q) begin
                state_d = S_DATA;
                cnt_d   = 3'd0;
            end
        end else if (!READ_ENABLE) begin
            state_d = S_IDLE;
            tmo_d   = '0;
        end else if (fall_q) begin
            // An edge always takes priority over the timeout.
            tmo_d = '0;
            case (state_q)
                S_DATA: begin
                    shift_d[cnt_q] = bit_q;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    perr_d  = ~(^shift_q ^ bit_q);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    byte_d  = shift_q;
                    err_d   = {~bit_q, perr_q};
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled frame: drop it silently, outputs keep their old values.
            state_d = S_IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = rdy_q;

endmodule

// File: tb/tb_mouse_receiver.sv
module tb_mouse_receiver;

    localparam int TMO  = 300;
    localparam int HALF = 15;   // CLK cycles per PS/2 clock half-period

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ms_clk;
    logic       ms_dat;
    logic       rd_en;
    logic [7:0] byte_read;
    logic [1:0] byte_err;
    logic       byte_rdy;

    mouse_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CLK_MOUSE_IN   (ms_clk),
        .DATA_MOUSE_IN  (ms_dat),
        .READ_ENABLE    (rd_en),
        .BYTE_READ      (byte_read),
        .BYTE_ERROR_CODE(byte_err),
        .BYTE_READY     (byte_rdy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [7:0] b;
        logic [1:0] e;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_rdy  = 0;
    bit   running = 1'b1;
    logic [7:0] held_b;
    logic [1:0] held_e;

    // Correct odd-parity bit for a byte.
    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Drives frame edges first..last-1 (index 0 = start bit, 10 = stop bit).
    // When expect_done is set, the stop edge registers an expected result
    // 4 CLK cycles later with status derived from the frame contents.
    task automatic send(input logic [7:0] d, input logic par, input logic stp,
                        input int first, input int last, input bit expect_done);
        logic [10:0] fr;
        exp_t        e;
        fr = {stp, par, d, 1'b0};
        for (int i = first; i < last; i++) begin
            @(negedge CLK);
            ms_dat = fr[i];
            repeat (HALF) @(negedge CLK);
            ms_clk = 1'b0;
            if (i == 10 && expect_done) begin
                e.cycle = cyc + 4;
                e.b     = d;
                e.e[1]  = (stp != 1'b1);
                e.e[0]  = ($countones({d, par}) % 2 == 0);
                expq.push_back(e);
            end
            repeat (HALF) @(negedge CLK);
            ms_clk = 1'b1;
        end
        @(negedge CLK);
        ms_dat = 1'b1;
    endtask

    // Per-cycle compare against the scoreboard.
    initial begin
        logic exp_r;
        held_b = 8'h00;
        held_e = 2'b00;
        forever begin
            @(posedge CLK);
            #1;
            if (!running) break;
            exp_r = 1'b0;
            if (RESET !== 1'b1) begin
                expq.delete();
                held_b = 8'h00;
                held_e = 2'b00;
            end else begin
                if (expq.size() > 0 && expq[0].cycle < cyc) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missed_pulse: got none want byte %h at cycle %0d", expq[0].b, expq[0].cycle);
                    void'(expq.pop_front());
                end
                if (expq.size() > 0 && expq[0].cycle == cyc) begin
                    held_b = expq[0].b;
                    held_e = expq[0].e;
                    exp_r  = 1'b1;
                    void'(expq.pop_front());
                end
            end
            n_cmp++;
            if (byte_rdy !== exp_r || byte_read !== held_b || byte_err !== held_e) begin
                n_fail++;
                $display("FAIL cycle_%0d rdy/byte/err: got %b/%h/%b want %b/%h/%b",
                         cyc, byte_rdy, byte_read, byte_err, exp_r, held_b, held_e);
            end
            if (byte_rdy === 1'b1) n_rdy++;
        end
    end

    initial begin
        int r0;
        RESET  = 1'b0;
        ms_clk = 1'b1;
        ms_dat = 1'b1;
        rd_en  = 1'b1;
        repeat (5) @(negedge CLK);
        chk("reset_byte", int'(byte_read), 8'h00);
        chk("reset_err", int'(byte_err), 0);
        chk("reset_rdy", int'(byte_rdy), 0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        // Good frame 0xFA
        r0 = n_rdy;
        send(8'hFA, 1'b1, 1'b1, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("fa_byte", int'(byte_read), 8'hFA);
        chk("fa_err", int'(byte_err), 0);
        chk("fa_pulses", n_rdy - r0, 1);

        // Parity error and stop-bit error
        send(8'hAA, 1'b0, 1'b1, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("aa_byte", int'(byte_read), 8'hAA);
        chk("aa_err", int'(byte_err), 1);
        send(8'hF4, 1'b0, 1'b0, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("f4stop_byte", int'(byte_read), 8'hF4);
        chk("f4stop_err", int'(byte_err), 2);

        // Stalled frame times out, then a clean frame
        r0 = n_rdy;
        send(8'h5A, 1'b1, 1'b1, 0, 5, 1'b0);
        repeat (TMO + 10) @(negedge CLK);
        send(8'hF4, odd_par(8'hF4), 1'b1, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("tmo_pulses", n_rdy - r0, 1);
        chk("tmo_byte", int'(byte_read), 8'hF4);
        chk("tmo_err", int'(byte_err), 0);

        // Enable dropped after bit 3; rest of frame arrives while disabled
        r0 = n_rdy;
        send(8'h08, odd_par(8'h08), 1'b1, 0, 5, 1'b0);
        rd_en = 1'b0;
        send(8'h08, odd_par(8'h08), 1'b1, 5, 11, 1'b0);
        // A whole frame while disabled is also ignored
        send(8'h33, odd_par(8'h33), 1'b1, 0, 11, 1'b0);
        repeat (5) @(negedge CLK);
        rd_en = 1'b1;
        repeat (5) @(negedge CLK);
        chk("drop_pulses", n_rdy - r0, 0);
        chk("drop_byte", int'(byte_read), 8'hF4);
        chk("drop_err", int'(byte_err), 0);

        // Back-to-back frames
        r0 = n_rdy;
        send(8'h08, odd_par(8'h08), 1'b1, 0, 11, 1'b1);
        send(8'h05, odd_par(8'h05), 1'b1, 0, 11, 1'b1);
        send(8'hFE, odd_par(8'hFE), 1'b1, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("b2b_pulses", n_rdy - r0, 3);
        chk("b2b_byte", int'(byte_read), 8'hFE);

        // Reset in the middle of a frame
        send(8'hFF, 1'b1, 1'b1, 0, 7, 1'b0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst_byte", int'(byte_read), 8'h00);
        chk("midrst_err", int'(byte_err), 0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        send(8'h3C, odd_par(8'h3C), 1'b1, 0, 11, 1'b1);
        repeat (10) @(negedge CLK);
        chk("3c_byte", int'(byte_read), 8'h3C);
        chk("3c_err", int'(byte_err), 0);

        repeat (5) @(negedge CLK);
        running = 1'b0;
        chk("queue_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mouse_receiver.md
MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, maximum CLK cycles allowed between consecutive PS/2 clock falling edges inside a frame.
REQ-002 CLK  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 CLK_MOUSE_IN  input  1  raw PS/2 clock line from the mouse, asynchronous to CLK.
REQ-005 DATA_MOUSE_IN  input  1  raw PS/2 data line from the mouse, asynchronous to CLK.
REQ-006 READ_ENABLE  input  1  receiver enable from the mouse master state machine; high means accept frames.
REQ-007 BYTE_READ  output  8  last received data byte.
REQ-008 BYTE_ERROR_CODE  output  2  status of the last byte: bit0 = parity error, bit1 = stop-bit error.
REQ-009 BYTE_READY  output  1  single-cycle pulse marking BYTE_READ/BYTE_ERROR_CODE valid.

Function
REQ-010 CLK_MOUSE_IN and DATA_MOUSE_IN shall each pass through a 2-flop synchronizer before use.
REQ-011 A falling edge shall be detected when the synchronized clock is 0 and its one-cycle-delayed copy is 1; all bit sampling shall occur on that detect cycle using the synchronized data.
REQ-012 Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1); 11 falling edges per frame.
REQ-013 States: IDLE, DATA, PARITY, STOP; a 3-bit bit counter shall index data bits 0-7.
REQ-014 IDLE: on falling edge with READ_ENABLE=1 and data=0 -> DATA, counter=0; data=1 at that edge (spurious start) -> remain IDLE, no output.
REQ-015 DATA: each falling edge shifts data into bit[counter]; after bit 7 -> PARITY.
REQ-016 PARITY: on falling edge, parity error flag = (XOR of 8 data bits XOR sampled parity) != 1; -> STOP.
REQ-017 STOP: on falling edge, stop error flag = (sampled bit != 1); BYTE_READ, BYTE_ERROR_CODE updated and BYTE_READY pulsed on the next CLK cycle; -> IDLE.
REQ-018 Latency: BYTE_READY shall assert exactly 4 CLK cycles after the stop-bit falling edge reaches CLK_MOUSE_IN (2 sync, 1 edge detect, 1 output register).
REQ-019 BYTE_READY shall be high for exactly one CLK cycle per completed frame, including frames with errors.
REQ-020 BYTE_READ and BYTE_ERROR_CODE shall hold their values between BYTE_READY pulses.
REQ-021 A timeout counter shall clear on every falling edge and increment in every non-IDLE state; reaching TIMEOUT_CYCLES shall abort to IDLE with no BYTE_READY and outputs unchanged.
REQ-022 READ_ENABLE low in any non-IDLE state shall abort to IDLE on the next cycle, no BYTE_READY.
REQ-023 READ_ENABLE low in IDLE shall ignore all falling edges.
REQ-024 Timeout and falling edge in the same cycle: the edge wins (counter clears, bit sampled).
REQ-025 Block shall never drive the PS/2 lines; it is receive-only.

Reset
REQ-026 RESET low shall force state IDLE, counters 0, synchronizers to 1, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0.
REQ-027 RESET asserted mid-frame shall discard the partial frame; first frame after release shall be received normally.

Verification
REQ-028 READ_ENABLE=1, frame 0xFA, parity 1, stop 1 -> one BYTE_READY pulse, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b00, 4 cycles after stop edge.
REQ-029 Frame 0xAA with parity 0 (wrong) -> BYTE_READ=8'hAA, BYTE_ERROR_CODE=2'b01; frame 0xF4 with stop bit 0 -> BYTE_ERROR_CODE=2'b10.
REQ-030 Four data bits of a frame, then clock idle for TIMEOUT_CYCLES+10 cycles, then full frame 0xF4 -> exactly one BYTE_READY, BYTE_READ=8'hF4, BYTE_ERROR_CODE=2'b00.
REQ-031 READ_ENABLE dropped after bit 3 of frame 0x08 -> no BYTE_READY; outputs retain previous values.
REQ-032 Three back-to-back frames 0x08, 0x05, 0xFE -> three single-cycle BYTE_READY pulses with those values in order.
REQ-033 RESET pulsed low after bit 5 of a frame, then frame 0x3C -> outputs 0 during reset, then BYTE_READ=8'h3C, BYTE_ERROR_CODE=2'b00.
